instr_encode_loader: RTL and testbench

//  Write-side counterpart of the instruction decoder. Packs opcode/register/immediate/offset fields

---
 rtl/instr_encode_loader.sv | 140 ++++++++++++++
 tb/tb_instr_encode_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - packs instruction fields into a 32-bit word and writes it as four bytes
// Optional LOADER_CHECKSUM_EN adds CHECKSUM/CHECKSUM_CLR: running mod-256 sum of written bytes.
module instr_encode_loader #(
  parameter int AW = 10,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [1:0]    FMT,
  input  logic [7:0]    OPCODE,
  input  logic [2:0]    DEST,
  input  logic [2:0]    SRC1,
  input  logic [2:0]    SRC2,
  input  logic [7:0]    IMMEDIATE,
  input  logic [7:0]    OFFSET,
  input  logic          LOAD_ADDR,
  input  logic [AW-1:0] START_ADDR,
  output logic          MEM_WRITE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [7:0]    MEM_WRITEDATA,
  input  logic          MEM_BUSYWAIT,
  output logic [31:0]   INSTR_WORD,
  output logic          DONE,
  output logic [CW-1:0] COUNT
`ifdef LOADER_CHECKSUM_EN
  ,
  input  logic          CHECKSUM_CLR,
  output logic [7:0]    CHECKSUM
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_WR1  = 3'd2,
    S_WR2  = 3'd3,
    S_WR3  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_base;
  logic [31:0]   r_word;
  logic [7:0]    r_last_byte;
  logic          r_done;
  logic [CW-1:0] r_count;

  logic          w_idle;
  logic          w_writing;
  logic [1:0]    w_beat;
  logic          w_accept;
  logic          w_beat_done;
  logic          w_word_done;
  logic [31:0]   w_packed;

  always_comb begin
    w_packed = 32'h0;
    case (FMT)
      2'd1:    w_packed = {OPCODE, 5'b0, DEST, 5'b0, SRC1, IMMEDIATE};
      2'd2:    w_packed = {OPCODE, OFFSET, 5'b0, SRC1, 5'b0, SRC2};
      default: w_packed = {OPCODE, 5'b0, DEST, 5'b0, SRC1, 5'b0, SRC2};
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_WR0;
      S_WR0:   if (!MEM_BUSYWAIT) w_next_state = S_WR1;
      S_WR1:   if (!MEM_BUSYWAIT) w_next_state = S_WR2;
      S_WR2:   if (!MEM_BUSYWAIT) w_next_state = S_WR3;
      S_WR3:   if (!MEM_BUSYWAIT) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_idle    = 1'b0;
    w_writing = 1'b0;
    w_beat    = 2'd0;
    case (r_state)
      S_IDLE:  w_idle = 1'b1;
      S_WR0:   begin w_writing = 1'b1; w_beat = 2'd0; end
      S_WR1:   begin w_writing = 1'b1; w_beat = 2'd1; end
      S_WR2:   begin w_writing = 1'b1; w_beat = 2'd2; end
      S_WR3:   begin w_writing = 1'b1; w_beat = 2'd3; end
      default: w_idle = 1'b1;
    endcase
    IN_READY      = w_idle & ~LOAD_ADDR & ~RESET;
    MEM_WRITE     = w_writing;
    MEM_ADDR      = r_base + AW'(w_beat);
    MEM_WRITEDATA = w_writing ? r_word[8*w_beat +: 8] : r_last_byte;
  end

  assign w_accept    = IN_VALID & IN_READY;
  assign w_beat_done = w_writing & ~MEM_BUSYWAIT;
  assign w_word_done = w_beat_done & (w_beat == 2'd3);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_base      <= '0;
      r_word      <= 32'h0;
      r_last_byte <= 8'h0;
      r_done      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_done <= w_word_done;
      if (w_idle && LOAD_ADDR) r_base <= START_ADDR;
      else if (w_word_done)    r_base <= r_base + AW'(4);
      if (w_accept)    r_word      <= w_packed;
      if (w_beat_done) r_last_byte <= MEM_WRITEDATA;
      if (w_word_done) r_count     <= r_count + 1'b1;
    end
  end

  assign INSTR_WORD = r_word;
  assign DONE       = r_done;
  assign COUNT      = r_count;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Clear wins over a byte completing in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)             r_checksum <= 8'h0;
    else if (CHECKSUM_CLR) r_checksum <= 8'h0;
    else if (w_beat_done)  r_checksum <= r_checksum + MEM_WRITEDATA;
  end

  assign CHECKSUM = r_checksum;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - self-checking bench for instr_encode_loader
// Builds with or without LOADER_CHECKSUM_EN.
module tb_instr_encode_loader;
  localparam int AW = 10;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IN_VALID;
  logic          IN_READY;
  logic [1:0]    FMT;
  logic [7:0]    OPCODE;
  logic [2:0]    DEST, SRC1, SRC2;
  logic [7:0]    IMMEDIATE, OFFSET;
  logic          LOAD_ADDR;
  logic [AW-1:0] START_ADDR;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_WRITEDATA;
  logic          MEM_BUSYWAIT;
  logic [31:0]   INSTR_WORD;
  logic          DONE;
  logic [CW-1:0] COUNT;
`ifdef LOADER_CHECKSUM_EN
  logic          CHECKSUM_CLR;
  logic [7:0]    CHECKSUM;
`endif

  instr_encode_loader #(.AW(AW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FMT(FMT), .OPCODE(OPCODE), .DEST(DEST), .SRC1(SRC1), .SRC2(SRC2),
    .IMMEDIATE(IMMEDIATE), .OFFSET(OFFSET), .LOAD_ADDR(LOAD_ADDR),
    .START_ADDR(START_ADDR), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .INSTR_WORD(INSTR_WORD), .DONE(DONE), .COUNT(COUNT)
`ifdef LOADER_CHECKSUM_EN
    , .CHECKSUM_CLR(CHECKSUM_CLR), .CHECKSUM(CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state
  int unsigned m_base;
  int unsigned m_count;
  int unsigned m_last;
  int unsigned m_word;
  int unsigned m_csum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_pack(input int unsigned fmt, input int unsigned op,
      input int unsigned d, input int unsigned s1, input int unsigned s2,
      input int unsigned imm, input int unsigned off);
    int unsigned w;
    w = op * 16777216;
    if (fmt == 1)      w = w + d * 65536 + s1 * 256 + imm;
    else if (fmt == 2) w = w + off * 65536 + s1 * 256 + s2;
    else               w = w + d * 65536 + s1 * 256 + s2;
    return w;
  endfunction

  function automatic int unsigned byte_of(input int unsigned w, input int k);
    return (w / (1 << (8 * k))) % 256;
  endfunction

  task automatic do_instr(input int unsigned fmt, input int unsigned op, input int unsigned d,
      input int unsigned s1, input int unsigned s2, input int unsigned imm, input int unsigned off,
      input int stall_beat, input int stall_n);
    @(negedge CLK);
    chk("idle_ready", {31'b0, IN_READY}, 32'd1);
    chk("idle_done_low", {31'b0, DONE}, 32'd0);
    FMT = 2'(fmt); OPCODE = 8'(op); DEST = 3'(d); SRC1 = 3'(s1); SRC2 = 3'(s2);
    IMMEDIATE = 8'(imm); OFFSET = 8'(off); IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    m_word = model_pack(fmt, op, d, s1, s2, imm, off);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("beat_write", {31'b0, MEM_WRITE}, 32'd1);
      chk("beat_addr", {22'b0, MEM_ADDR}, (m_base + k) % 1024);
      chk("beat_data", {24'b0, MEM_WRITEDATA}, byte_of(m_word, k));
      if (k == stall_beat && stall_n > 0) begin
        MEM_BUSYWAIT = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge CLK);
          chk("stall_write", {31'b0, MEM_WRITE}, 32'd1);
          chk("stall_addr", {22'b0, MEM_ADDR}, (m_base + k) % 1024);
          chk("stall_data", {24'b0, MEM_WRITEDATA}, byte_of(m_word, k));
        end
        MEM_BUSYWAIT = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) m_csum = (m_csum + byte_of(m_word, k)) % 256;
    m_base  = (m_base + 4) % 1024;
    m_count = (m_count + 1) % 65536;
    m_last  = byte_of(m_word, 3);
    @(negedge CLK);
    chk("done_pulse", {31'b0, DONE}, 32'd1);
    chk("done_ready", {31'b0, IN_READY}, 32'd1);
    chk("done_write_low", {31'b0, MEM_WRITE}, 32'd0);
    chk("instr_word", INSTR_WORD, m_word);
    chk("count", {16'b0, COUNT}, m_count);
    chk("idle_base", {22'b0, MEM_ADDR}, m_base);
    chk("idle_data_hold", {24'b0, MEM_WRITEDATA}, m_last);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", {24'b0, CHECKSUM}, m_csum);
`endif
  endtask

  task automatic load_base(input int unsigned addr);
    @(negedge CLK);
    LOAD_ADDR = 1'b1; START_ADDR = AW'(addr); IN_VALID = 1'b1;
    #1;
    chk("load_ready_low", {31'b0, IN_READY}, 32'd0);
    @(negedge CLK);
    LOAD_ADDR = 1'b0; IN_VALID = 1'b0;
    m_base = addr % 1024;
    chk("load_no_write", {31'b0, MEM_WRITE}, 32'd0);
    chk("load_base", {22'b0, MEM_ADDR}, m_base);
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; FMT = 2'd0; OPCODE = 8'h0; DEST = 3'd0; SRC1 = 3'd0;
    SRC2 = 3'd0; IMMEDIATE = 8'h0; OFFSET = 8'h0; LOAD_ADDR = 1'b0; START_ADDR = '0;
    MEM_BUSYWAIT = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    CHECKSUM_CLR = 1'b0;
`endif
    m_base = 0; m_count = 0; m_last = 0; m_word = 0; m_csum = 0;
    #12;
    chk("rst_ready", {31'b0, IN_READY}, 32'd0);
    chk("rst_write", {31'b0, MEM_WRITE}, 32'd0);
    chk("rst_addr", {22'b0, MEM_ADDR}, 32'd0);
    chk("rst_data", {24'b0, MEM_WRITEDATA}, 32'd0);
    chk("rst_word", INSTR_WORD, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    chk("rst_count", {16'b0, COUNT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    do_instr(1, 8'h00, 2, 0, 0, 8'h2A, 0, 4, 0);
    chk("t1_word", INSTR_WORD, 32'h0002002A);
    chk("t1_base", {22'b0, MEM_ADDR}, 32'd4);
    do_instr(2, 8'h07, 0, 1, 3, 0, 8'hFE, 4, 0);
    chk("t2_fmt2_word", INSTR_WORD, 32'h07FE0103);
`ifdef LOADER_CHECKSUM_EN
    chk("t6_checksum", {24'b0, CHECKSUM}, 32'h35);
`endif
    do_instr(0, 8'h02, 7, 5, 6, 8'h99, 8'h55, 4, 0);
    chk("t2_fmt0_word", INSTR_WORD, 32'h02070506);
    do_instr(3, 8'h02, 7, 5, 6, 8'h99, 8'h55, 4, 0);
    chk("t2_fmt3_word", INSTR_WORD, 32'h02070506);

    do_instr(1, 8'hA5, 3, 4, 0, 8'h11, 0, 1, 3);

    load_base(10'h3FE);
    do_instr(0, 8'h5C, 1, 2, 3, 0, 0, 4, 0);
    chk("t4_wrap_base", {22'b0, MEM_ADDR}, 32'h002);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) load_base($urandom_range(0, 1023));
      do_instr($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // Reset while the third byte is on the bus
    @(negedge CLK);
    FMT = 2'd1; OPCODE = 8'h33; DEST = 3'd4; SRC1 = 3'd1; IMMEDIATE = 8'h77; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5_in_wr2", {22'b0, MEM_ADDR}, (m_base + 2) % 1024);
    #2 RESET = 1'b1;
    #1;
    chk("t5_write_low", {31'b0, MEM_WRITE}, 32'd0);
    chk("t5_count", {16'b0, COUNT}, 32'd0);
    chk("t5_addr", {22'b0, MEM_ADDR}, 32'd0);
    chk("t5_ready_low", {31'b0, IN_READY}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    m_base = 0; m_count = 0; m_last = 0; m_csum = 0;
    repeat (4) begin
      @(negedge CLK);
      chk("t5_no_done", {31'b0, DONE}, 32'd0);
    end
    do_instr(2, 8'h81, 0, 6, 2, 0, 8'h80, 2, 2);
    chk("t5_fresh_count", {16'b0, COUNT}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    @(negedge CLK);
    CHECKSUM_CLR = 1'b1;
    @(negedge CLK);
    CHECKSUM_CLR = 1'b0;
    chk("t6_checksum_clr", {24'b0, CHECKSUM}, 32'h00);
    m_csum = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
